// File: rtl/set_assoc_lru.sv
// Per-set LRU age tracker with a registered victim selector (invalid way first, then oldest unlocked way).
// Define SET_ASSOC_LRU_LOCK_EN to add per-way lock bits and a functional victim_none output.
module set_assoc_lru #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int AW = $clog2(WAYS),
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            access_valid,
  input  logic [SW-1:0]   access_set,
  input  logic [AW-1:0]   access_way,
  input  logic            victim_req,
  input  logic [SW-1:0]   victim_set,
  input  logic [WAYS-1:0] valid_mask,
`ifdef SET_ASSOC_LRU_LOCK_EN
  input  logic            lock_valid,
  input  logic [SW-1:0]   lock_set,
  input  logic [AW-1:0]   lock_way,
  input  logic            lock_value,
`endif
  output logic            victim_valid,
  output logic [AW-1:0]   victim_way,
  output logic [WAYS-1:0] victim_onehot,
  output logic            victim_none
);

  logic [AW-1:0]   age_q [SETS][WAYS];
  logic [AW-1:0]   acc_age;
  logic [WAYS-1:0] set_lock;

  logic [AW-1:0]   sel_way;
  logic [WAYS-1:0] sel_onehot;
  logic            sel_none;
  logic            sel_found;
  logic [AW-1:0]   best_age;

  logic            vld_p1;
  logic [AW-1:0]   way_p1;
  logic [WAYS-1:0] onehot_p1;
  logic            none_p1;

  assign acc_age = age_q[access_set][access_way];

  // Accessed way becomes youngest; only ways younger than it age by one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AW'(w);
    end else if (access_valid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == access_way)
          age_q[access_set][w] <= '0;
        else if (age_q[access_set][w] < acc_age)
          age_q[access_set][w] <= age_q[access_set][w] + 1'b1;
      end
    end
  end

`ifdef SET_ASSOC_LRU_LOCK_EN
  logic [WAYS-1:0] lock_q [SETS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++)
        lock_q[s] <= '0;
    end else if (lock_valid) begin
      lock_q[lock_set][lock_way] <= lock_value;
    end
  end

  assign set_lock = lock_q[victim_set];
`else
  assign set_lock = '0;
`endif

  // Victim choice from pre-edge ages and locks.
  always_comb begin
    sel_way   = '0;
    sel_found = 1'b0;
    best_age  = '0;
    if (!(&valid_mask)) begin
      sel_found = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid_mask[w])
          sel_way = AW'(w);
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (!set_lock[w] && (!sel_found || age_q[victim_set][w] > best_age)) begin
          sel_found = 1'b1;
          best_age  = age_q[victim_set][w];
          sel_way   = AW'(w);
        end
      end
    end
    sel_none   = !sel_found;
    sel_onehot = sel_none ? '0 : (WAYS'(1) << sel_way);
  end

  // Stage p1: registered victim; payload holds between requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      way_p1    <= '0;
      onehot_p1 <= '0;
      none_p1   <= 1'b0;
    end else begin
      vld_p1 <= victim_req;
      if (victim_req) begin
        way_p1    <= sel_way;
        onehot_p1 <= sel_onehot;
        none_p1   <= sel_none;
      end
    end
  end

  assign victim_valid  = vld_p1;
  assign victim_way    = way_p1;
  assign victim_onehot = onehot_p1;
`ifdef SET_ASSOC_LRU_LOCK_EN
  assign victim_none   = none_p1;
`else
  assign victim_none   = 1'b0;
`endif

endmodule

// File: tb/tb_set_assoc_lru.sv
// Bench for set_assoc_lru (WAYS=4, SETS=16): vector table plus hand sequences, scoreboard of expected victims.
module tb_set_assoc_lru;
  localparam int WAYS = 4;
  localparam int SETS = 16;

  logic       clock;
  logic       reset;
  logic       access_valid;
  logic [3:0] access_set;
  logic [1:0] access_way;
  logic       victim_req;
  logic [3:0] victim_set;
  logic [3:0] valid_mask;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic [3:0] victim_onehot;
  logic       victim_none;
`ifdef SET_ASSOC_LRU_LOCK_EN
  logic       lock_valid;
  logic [3:0] lock_set;
  logic [1:0] lock_way;
  logic       lock_value;
`endif

  set_assoc_lru #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clock(clock), .reset(reset),
    .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
    .victim_req(victim_req), .victim_set(victim_set), .valid_mask(valid_mask),
`ifdef SET_ASSOC_LRU_LOCK_EN
    .lock_valid(lock_valid), .lock_set(lock_set), .lock_way(lock_way), .lock_value(lock_value),
`endif
    .victim_valid(victim_valid), .victim_way(victim_way),
    .victim_onehot(victim_onehot), .victim_none(victim_none)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0] way;
    logic [3:0] onehot;
    logic       none;
  } exp_t;

  typedef struct {
    logic       acc_v;
    logic [3:0] acc_set;
    logic [1:0] acc_way;
    logic       vreq;
    logic [3:0] vset;
    logic [3:0] mask;
    logic [1:0] exp_way;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int av, input int as, input int aw,
                              input int vr, input int vs, input int m, input int ew);
    vec_t v;
    v.acc_v   = 1'(av);
    v.acc_set = 4'(as);
    v.acc_way = 2'(aw);
    v.vreq    = 1'(vr);
    v.vset    = 4'(vs);
    v.mask    = 4'(m);
    v.exp_way = 2'(ew);
    return v;
  endfunction

  task automatic idle_inputs();
    access_valid = 1'b0;
    access_set   = '0;
    access_way   = '0;
    victim_req   = 1'b0;
    victim_set   = '0;
    valid_mask   = 4'hF;
`ifdef SET_ASSOC_LRU_LOCK_EN
    lock_valid   = 1'b0;
    lock_set     = '0;
    lock_way     = '0;
    lock_value   = 1'b0;
`endif
  endtask

  task automatic push_exp(input logic [1:0] way, input logic none);
    exp_t e;
    e.way    = none ? 2'd0 : way;
    e.onehot = none ? 4'd0 : (4'd1 << way);
    e.none   = none;
    exp_q.push_back(e);
  endtask

  // One clock: let the edge pass, then check the scoreboard against the registered outputs.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("victim_valid", 32'(victim_valid), 32'd1);
      chk("victim_way", 32'(victim_way), 32'(e.way));
      chk("victim_onehot", 32'(victim_onehot), 32'(e.onehot));
      chk("victim_none", 32'(victim_none), 32'(e.none));
    end else begin
      chk("victim_valid_idle", 32'(victim_valid), 32'd0);
    end
    idle_inputs();
  endtask

  task automatic req(input int s, input logic [3:0] m, input int exp_way, input logic none);
    victim_req = 1'b1;
    victim_set = 4'(s);
    valid_mask = m;
    push_exp(2'(exp_way), none);
  endtask

`ifdef SET_ASSOC_LRU_LOCK_EN
  task automatic lock(input int s, input int w, input logic v);
    lock_valid = 1'b1;
    lock_set   = 4'(s);
    lock_way   = 2'(w);
    lock_value = v;
  endtask
`endif

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    chk("reset_valid", 32'(victim_valid), 32'd0);
    chk("reset_way", 32'(victim_way), 32'd0);
    chk("reset_onehot", 32'(victim_onehot), 32'd0);
    chk("reset_none", 32'(victim_none), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    //           acc set way vreq set mask  exp
    vecs[0]  = mk(0, 0, 0, 1, 5,  'hF, 3);
    vecs[1]  = mk(1, 0, 3, 0, 0,  'hF, 0);
    vecs[2]  = mk(1, 0, 1, 0, 0,  'hF, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0,  'hF, 2);
    vecs[4]  = mk(0, 0, 0, 1, 1,  'hF, 3);
    vecs[5]  = mk(0, 0, 0, 1, 0,  'hB, 2);
    vecs[6]  = mk(0, 0, 0, 1, 0,  'h6, 0);
    vecs[7]  = mk(1, 2, 3, 1, 2,  'hF, 3);
    vecs[8]  = mk(0, 0, 0, 1, 2,  'hF, 2);
    vecs[9]  = mk(1, 0, 2, 1, 0,  'hF, 2);
    vecs[10] = mk(0, 0, 0, 1, 0,  'hF, 0);
    vecs[11] = mk(1, 0, 1, 1, 15, 'h0, 0);
    vecs[12] = mk(0, 0, 0, 1, 0,  'hF, 0);
    vecs[13] = mk(1, 0, 1, 1, 0,  'hF, 0);
    vecs[14] = mk(0, 0, 0, 1, 0,  'hF, 0);
    vecs[15] = mk(0, 0, 0, 1, 0,  'h7, 3);

    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) begin
      access_valid = vecs[i].acc_v;
      access_set   = vecs[i].acc_set;
      access_way   = vecs[i].acc_way;
      if (vecs[i].vreq)
        req(int'(vecs[i].vset), vecs[i].mask, int'(vecs[i].exp_way), 1'b0);
      tick();
    end

    // No request: valid drops, payload holds the last victim (way 3).
    tick();
    chk("hold_way", 32'(victim_way), 32'd3);
    chk("hold_onehot", 32'(victim_onehot), 32'h8);

`ifdef SET_ASSOC_LRU_LOCK_EN
    // Set 3 is still at reset order.
    lock(3, 3, 1'b1);
    req(3, 4'hF, 3, 1'b0);
    tick();
    req(3, 4'hF, 2, 1'b0);
    tick();
    lock(3, 0, 1'b1); tick();
    lock(3, 1, 1'b1); tick();
    lock(3, 2, 1'b1); tick();
    req(3, 4'hF, 0, 1'b1);
    tick();
    req(3, 4'hB, 2, 1'b0);
    tick();
    lock(3, 1, 1'b0); tick();
    req(3, 4'hF, 1, 1'b0);
    tick();
`endif

    // Asynchronous reset in the middle of a valid cycle.
    req(4, 4'hF, 3, 1'b0);
    tick();
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(victim_valid), 32'd0);
    chk("async_way", 32'(victim_way), 32'd0);
    chk("async_onehot", 32'(victim_onehot), 32'd0);
    chk("async_none", 32'(victim_none), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int s = 0; s < SETS; s++) begin
      req(s, 4'hF, 3, 1'b0);
      tick();
    end
    tick();

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
